// File: rtl/riscv_instr_aligner.sv
// Realigns 32-bit fetch words into whole RV32 instructions (16/32-bit, straddles included).
// Latency: an accepted fetch word yields instr_valid_o on the next cycle.
// Backpressure: instr_ready_i low holds the output register and fetch_ready_o drops (except in SKIP).
module riscv_instr_aligner (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic [31:0] flush_addr_i,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_rdata_i,
    input  logic [31:0] fetch_addr_i,
    output logic        fetch_ready_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_addr_o,
    output logic        is_compressed_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        SKIP  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] res_q, res_d;
    logic [31:0] res_addr_q, res_addr_d;

    logic        vld_d;
    logic [31:0] dat_d;
    logic [31:0] addr_d;
    logic        cmp_d;

    logic        out_free;
    logic        res_is_c;
    logic        low_is_c;
    logic        fetch_take;
    logic [31:0] fetch_addr_p2;

    // Only the halfword-select bit of the redirect target and the word part of the fetch address matter.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{flush_addr_i[31:2], flush_addr_i[0], fetch_addr_i[1:0]};

    assign out_free      = !instr_valid_o || instr_ready_i;
    assign res_is_c      = (res_q[1:0] != 2'b11);
    assign low_is_c      = (fetch_rdata_i[1:0] != 2'b11);
    assign fetch_addr_p2 = fetch_addr_i + 32'd2;

    assign fetch_ready_o = !flush_i &&
                           ((state_q == SKIP) ||
                            (out_free && ((state_q == EMPTY) ||
                                          ((state_q == HALF) && !res_is_c))));
    assign fetch_take    = fetch_valid_i && fetch_ready_o;

    always_comb begin
        state_d    = state_q;
        res_d      = res_q;
        res_addr_d = res_addr_q;
        // A completed or absent handshake empties the output; a stalled one holds it.
        vld_d      = instr_valid_o && !instr_ready_i;
        dat_d      = instr_o;
        addr_d     = instr_addr_o;
        cmp_d      = is_compressed_o;

        if (flush_i) begin
            vld_d      = 1'b0;
            res_d      = 16'h0000;
            res_addr_d = 32'h0000_0000;
            state_d    = flush_addr_i[1] ? SKIP : EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (fetch_take) begin
                        vld_d  = 1'b1;
                        addr_d = fetch_addr_i;
                        if (low_is_c) begin
                            dat_d      = {16'h0000, fetch_rdata_i[15:0]};
                            cmp_d      = 1'b1;
                            res_d      = fetch_rdata_i[31:16];
                            res_addr_d = fetch_addr_p2;
                            state_d    = HALF;
                        end else begin
                            dat_d = fetch_rdata_i;
                            cmp_d = 1'b0;
                        end
                    end
                end
                HALF: begin
                    if (out_free && res_is_c) begin
                        vld_d   = 1'b1;
                        dat_d   = {16'h0000, res_q};
                        addr_d  = res_addr_q;
                        cmp_d   = 1'b1;
                        state_d = EMPTY;
                    end else if (fetch_take) begin
                        // Residue is the low half of a 32-bit instruction straddling into this word.
                        vld_d      = 1'b1;
                        dat_d      = {fetch_rdata_i[15:0], res_q};
                        addr_d     = res_addr_q;
                        cmp_d      = 1'b0;
                        res_d      = fetch_rdata_i[31:16];
                        res_addr_d = fetch_addr_p2;
                    end
                end
                SKIP: begin
                    if (fetch_take) begin
                        res_d      = fetch_rdata_i[31:16];
                        res_addr_d = fetch_addr_p2;
                        state_d    = HALF;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= EMPTY;
            res_q           <= 16'h0000;
            res_addr_q      <= 32'h0000_0000;
            instr_valid_o   <= 1'b0;
            instr_o         <= 32'h0000_0000;
            instr_addr_o    <= 32'h0000_0000;
            is_compressed_o <= 1'b0;
        end else begin
            state_q         <= state_d;
            res_q           <= res_d;
            res_addr_q      <= res_addr_d;
            instr_valid_o   <= vld_d;
            instr_o         <= dat_d;
            instr_addr_o    <= addr_d;
            is_compressed_o <= cmp_d;
        end
    end

endmodule

// File: tb/tb_riscv_instr_aligner.sv
// Bench for riscv_instr_aligner: directed scenarios plus a randomized stream
// scored against a halfword-queue reference model.
module tb_riscv_instr_aligner;

    logic        clk;
    logic        rst_n;
    logic        flush_i;
    logic [31:0] flush_addr_i;
    logic        fetch_valid_i;
    logic [31:0] fetch_rdata_i;
    logic [31:0] fetch_addr_i;
    logic        fetch_ready_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_addr_o;
    logic        is_compressed_o;

    riscv_instr_aligner dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush_i         (flush_i),
        .flush_addr_i    (flush_addr_i),
        .fetch_valid_i   (fetch_valid_i),
        .fetch_rdata_i   (fetch_rdata_i),
        .fetch_addr_i    (fetch_addr_i),
        .fetch_ready_o   (fetch_ready_o),
        .instr_valid_o   (instr_valid_o),
        .instr_ready_i   (instr_ready_i),
        .instr_o         (instr_o),
        .instr_addr_o    (instr_addr_o),
        .is_compressed_o (is_compressed_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [15:0] hw;
        logic [31:0] addr;
    } hw_t;

    int          errors;
    int          checks;
    hw_t         hq[$];
    bit          skip_low;
    bit          hold_pend;
    logic [31:0] h_dat;
    logic [31:0] h_addr;
    logic        h_cmp;
    bit          fetch_acc;
    int          words_acc;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [31:0] dat, input logic [31:0] addr,
                              input logic cmp);
        chk({tag, "_vld"}, instr_valid_o, 1);
        chk({tag, "_dat"}, instr_o, dat);
        chk({tag, "_addr"}, instr_addr_o, addr);
        chk({tag, "_cmp"}, is_compressed_o, cmp);
    endtask

    // Reference: the fetched stream is a sequence of halfwords; each instruction
    // is one compressed halfword or two halfwords when the first has [1:0]==11.
    task automatic model_pop();
        int need;
        need = (hq.size() > 0 && hq[0].hw[1:0] != 2'b11) ? 1 : 2;
        chk("q_depth_ok", 32'(hq.size() >= need), 1);
        if (hq.size() >= need) begin
            if (need == 1) begin
                chk("sb_dat", instr_o, {16'h0000, hq[0].hw});
                chk("sb_cmp", is_compressed_o, 1);
            end else begin
                chk("sb_dat", instr_o, {hq[1].hw, hq[0].hw});
                chk("sb_cmp", is_compressed_o, 0);
            end
            chk("sb_addr", instr_addr_o, hq[0].addr);
            repeat (need) void'(hq.pop_front());
        end
    endtask

    task automatic monitor();
        hw_t e;
        fetch_acc = 0;
        if (hold_pend) begin
            chk("hold_vld", instr_valid_o, 1);
            chk("hold_dat", instr_o, h_dat);
            chk("hold_addr", instr_addr_o, h_addr);
            chk("hold_cmp", is_compressed_o, h_cmp);
        end
        if (instr_valid_o && instr_ready_i) model_pop();
        if (flush_i) chk("flush_rdy", fetch_ready_o, 0);
        if (fetch_valid_i && fetch_ready_o) begin
            fetch_acc = 1;
            words_acc++;
            if (!skip_low) begin
                e.hw   = fetch_rdata_i[15:0];
                e.addr = fetch_addr_i;
                hq.push_back(e);
            end
            e.hw   = fetch_rdata_i[31:16];
            e.addr = fetch_addr_i + 32'd2;
            hq.push_back(e);
            skip_low = 0;
        end
        if (flush_i) begin
            hq.delete();
            skip_low = flush_addr_i[1];
        end
        hold_pend = instr_valid_o && !instr_ready_i && !flush_i;
        h_dat     = instr_o;
        h_addr    = instr_addr_o;
        h_cmp     = is_compressed_o;
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] gen_hw();
        logic [15:0] h;
        h = 16'($urandom);
        if ($urandom % 2 == 0) h[1:0] = 2'b11;
        else h[1:0] = 2'($urandom_range(0, 2));
        return h;
    endfunction

    function automatic logic [31:0] gen_word();
        logic [15:0] lo;
        logic [15:0] hi;
        lo = gen_hw();
        hi = gen_hw();
        return {hi, lo};
    endfunction

    logic [31:0] cur_addr;
    logic [31:0] cur_word;
    logic [31:0] tgt;

    initial begin
        errors = 0;  checks = 0;  skip_low = 0;  hold_pend = 0;  words_acc = 0;
        rst_n = 1'b0;  flush_i = 1'b0;  flush_addr_i = '0;
        fetch_valid_i = 1'b0;  fetch_rdata_i = '0;  fetch_addr_i = '0;
        instr_ready_i = 1'b1;

        #12;
        chk("rst_vld", instr_valid_o, 0);
        chk("rst_dat", instr_o, 0);
        chk("rst_addr", instr_addr_o, 0);
        chk("rst_cmp", is_compressed_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_frdy", fetch_ready_o, 1);

        // Aligned 32-bit pair
        fetch_valid_i = 1;  fetch_rdata_i = 32'h00A00093;  fetch_addr_i = 32'h0;
        cycle();
        expect_out("al0", 32'h00A00093, 32'h0, 0);
        fetch_rdata_i = 32'h00B00113;  fetch_addr_i = 32'h4;
        cycle();
        expect_out("al1", 32'h00B00113, 32'h4, 0);
        fetch_valid_i = 0;
        cycle();
        chk("al_idle", instr_valid_o, 0);

        // Compressed pair in one word
        fetch_valid_i = 1;  fetch_rdata_i = 32'h00010505;  fetch_addr_i = 32'h100;
        cycle();
        expect_out("cp0", 32'h00000505, 32'h100, 1);
        fetch_valid_i = 0;
        #1 chk("cp_frdy", fetch_ready_o, 0);
        cycle();
        expect_out("cp1", 32'h00000001, 32'h102, 1);
        cycle();

        // Straddle
        fetch_valid_i = 1;  fetch_rdata_i = 32'h00930001;  fetch_addr_i = 32'h200;
        cycle();
        expect_out("st0", 32'h00000001, 32'h200, 1);
        fetch_rdata_i = 32'h00000000;  fetch_addr_i = 32'h204;
        cycle();
        expect_out("st1", 32'h00000093, 32'h202, 0);
        fetch_valid_i = 0;
        cycle();
        expect_out("st2", 32'h00000000, 32'h206, 1);
        cycle();

        // Backpressure
        fetch_valid_i = 1;  fetch_rdata_i = 32'h00A00093;  fetch_addr_i = 32'h400;
        cycle();
        instr_ready_i = 0;  fetch_rdata_i = 32'h00B00113;  fetch_addr_i = 32'h404;
        for (int i = 0; i < 3; i++) begin
            cycle();
            expect_out("bp_hold", 32'h00A00093, 32'h400, 0);
            chk("bp_frdy", fetch_ready_o, 0);
        end
        instr_ready_i = 1;
        cycle();
        expect_out("bp_next", 32'h00B00113, 32'h404, 0);
        fetch_valid_i = 0;
        cycle();

        // Flush to a halfword target, colliding with a fetch word
        flush_i = 1;  flush_addr_i = 32'h302;
        fetch_valid_i = 1;  fetch_rdata_i = 32'hDEADBEEF;  fetch_addr_i = 32'h500;
        #1 chk("fl_frdy", fetch_ready_o, 0);
        cycle();
        chk("fl_vld", instr_valid_o, 0);
        flush_i = 0;  fetch_rdata_i = 32'h12340001;  fetch_addr_i = 32'h300;
        #1 chk("skip_frdy", fetch_ready_o, 1);
        cycle();
        chk("skip_noemit", instr_valid_o, 0);
        fetch_valid_i = 0;
        cycle();
        expect_out("fl_tgt", 32'h00001234, 32'h302, 1);
        cycle();

        // Async reset while HALF with a pending output
        fetch_valid_i = 1;  fetch_rdata_i = 32'h00010505;  fetch_addr_i = 32'h600;
        cycle();
        chk("ar_pre", instr_valid_o, 1);
        instr_ready_i = 0;  fetch_valid_i = 0;
        #2 rst_n = 0;
        #1;
        chk("ar_vld", instr_valid_o, 0);
        chk("ar_dat", instr_o, 0);
        chk("ar_addr", instr_addr_o, 0);
        chk("ar_cmp", is_compressed_o, 0);
        hq.delete();  skip_low = 0;  hold_pend = 0;
        #1 rst_n = 1;
        instr_ready_i = 1;
        cycle();
        chk("ar_empty", instr_valid_o, 0);

        // Randomized stream with redirects, starting near the address wrap
        cur_addr = 32'hFFFF_FFF0;
        cur_word = gen_word();
        for (int i = 0; i < 2000; i++) begin
            instr_ready_i = ($urandom % 4) != 0;
            fetch_valid_i = ($urandom % 4) != 0;
            fetch_addr_i  = cur_addr;
            fetch_rdata_i = cur_word;
            flush_i       = ($urandom % 50) == 0;
            tgt           = $urandom;
            if ($urandom % 3 == 0) tgt[31:4] = '1;
            flush_addr_i  = tgt;
            cycle();
            if (flush_i) begin
                cur_addr = {flush_addr_i[31:2], 2'b00};
                cur_word = gen_word();
            end else if (fetch_acc) begin
                cur_addr = cur_addr + 32'd4;
                cur_word = gen_word();
            end
        end
        flush_i = 0;  fetch_valid_i = 0;  instr_ready_i = 1;
        repeat (6) cycle();
        chk("drain_vld", instr_valid_o, 0);
        chk("drain_left", 32'(hq.size() == 0 || (hq.size() == 1 && hq[0].hw[1:0] == 2'b11)), 1);
        chk("throughput", 32'(words_acc > 200), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
